// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage.
// Non-memory instructions pass straight through to a registered writeback
// result one cycle later. Loads and stores go out over a byte-wide bus one
// byte per cycle (little-endian) while the stage stalls the upstream.
// Load data returns on mem_din_i one cycle after its address.
//
// Optional feature: define MEM_MISALIGN_CHK_EN to reject memory ops whose
// address is not aligned to the access size. They never request the bus and
// complete in DONE with wreg_o=0 and misalign_o=1. Without the macro,
// misalign_o is tied low and misaligned accesses run byte-serially.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ex_valid_i          instruction presented by the execute stage
//   wd_i, wreg_i        destination register index / write enable
//   wdata_i             ALU result; the address for memory ops (low ADDR_W bits)
//   mem_w_data_i        store data
//   mem_op_i            [4] mem op, [3] store, [2] unsigned load, [1:0] size
//   stall_o             upstream holds its inputs while high
//   mem_req_o/mem_gnt_i bus request / grant
//   mem_a_o, mem_wr_o   byte address, write strobe
//   mem_dout_o          store byte; mem_din_i load byte
//   valid_o, wd_o, wreg_o, wdata_o  registered writeback result
//   misalign_o          misaligned access flag (MEM_MISALIGN_CHK_EN only)
// The design assumes ADDR_W <= DATA_W and ADDR_W >= 3.
module mem_access #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W-1:0]     mem_w_data_i,
  input  logic [4:0]            mem_op_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_W-1:0]     mem_a_o,
  output logic                  mem_wr_o,
  output logic [7:0]            mem_dout_o,
  input  logic [7:0]            mem_din_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  misalign_o
);

  localparam int unsigned NB_MAX = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WAIT_GNT, XFER, LAST, DONE} state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     alu_q;
  logic [DATA_W-1:0]     sdata_q;
  logic [DATA_W-1:0]     ldata_q;
  logic [REG_ADDR_W-1:0] wd_q;
  logic                  wreg_q;
  logic                  store_q;
  logic                  uns_q;
  logic [1:0]            size_q;

  logic [1:0]            in_size;
  logic [3:0]            in_nb;
  logic [3:0]            q_nb;
  logic                  last_byte;
  logic                  accept_mem;
  logic [DATA_W-1:0]     sh;
  logic [DATA_W-1:0]     fin_data;
  logic [DATA_W-1:0]     ld_result;

  function automatic logic [3:0] nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Keep the low nb bytes and fill above with the sign bit (or zeros).
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [3:0] nb,
                                               input logic uns);
    logic [DATA_W-1:0] mask;
    logic              sgn;
    mask = '0;
    sgn  = 1'b0;
    for (int unsigned i = 0; i < NB_MAX; i++) begin
      if (i < 32'(nb)) mask[i*8 +: 8] = '1;
      if (i == 32'(nb) - 1) sgn = raw[i*8 + 7];
    end
    return (raw & mask) | ((!uns && sgn) ? ~mask : '0);
  endfunction

  always_comb begin
    in_size = mem_op_i[1:0];
    // A doubleword request on a 32-bit datapath is treated as a word.
    if (DATA_W == 32 && in_size == 2'd3) in_size = 2'd2;
    in_nb      = nbytes(in_size);
    q_nb       = nbytes(size_q);
    last_byte  = (cnt == 3'(q_nb - 4'd1));
    accept_mem = (state == IDLE) && ex_valid_i && mem_op_i[4];

    stall_o   = (state == WAIT_GNT) || (state == XFER) || (state == LAST) || accept_mem;
    mem_req_o = (state == WAIT_GNT) || (state == XFER) || (state == LAST);
    mem_wr_o  = (state == XFER) && store_q;
    mem_a_o   = (state == XFER) ? addr_q + ADDR_W'(cnt) : '0;

    sh         = sdata_q >> {cnt, 3'b000};
    mem_dout_o = ((state == XFER) && store_q) ? sh[7:0] : '0;

    // Top load byte arrives in LAST; merge it before extension.
    fin_data = ldata_q;
    if (state == LAST) begin
      for (int unsigned i = 0; i < NB_MAX; i++)
        if (i == 32'(q_nb) - 1) fin_data[i*8 +: 8] = mem_din_i;
    end
    ld_result = extend(fin_data, q_nb, uns_q);
  end

`ifdef MEM_MISALIGN_CHK_EN
  logic in_mis;
  logic misalign_q;
  assign in_mis     = (wdata_i[2:0] & 3'(in_nb - 4'd1)) != 3'd0;
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      alu_q   <= '0;
      sdata_q <= '0;
      ldata_q <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      valid_o <= 1'b0;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
      wdata_o <= '0;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (ex_valid_i) begin
            if (!mem_op_i[4]) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else begin
              addr_q  <= wdata_i[ADDR_W-1:0];
              alu_q   <= wdata_i;
              sdata_q <= mem_w_data_i;
              ldata_q <= '0;
              wd_q    <= wd_i;
              wreg_q  <= wreg_i;
              store_q <= mem_op_i[3];
              uns_q   <= mem_op_i[2];
              size_q  <= in_size;
              cnt     <= '0;
`ifdef MEM_MISALIGN_CHK_EN
              if (in_mis) begin
                state      <= DONE;
                valid_o    <= 1'b1;
                wd_o       <= wd_i;
                wreg_o     <= 1'b0;
                wdata_o    <= wdata_i;
                misalign_q <= 1'b1;
              end else begin
                state <= WAIT_GNT;
              end
`else
              state <= WAIT_GNT;
`endif
            end
          end
        end
        WAIT_GNT: begin
          if (mem_gnt_i) begin
            cnt   <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          // Read data lags the address by one cycle: byte cnt-1 is on the bus now.
          if (!store_q && cnt != 3'd0) begin
            for (int unsigned i = 0; i < NB_MAX; i++)
              if (i == 32'(cnt) - 1) ldata_q[i*8 +: 8] <= mem_din_i;
          end
          cnt <= cnt + 3'd1;
          if (last_byte) begin
            if (store_q) begin
              state   <= DONE;
              valid_o <= 1'b1;
              wd_o    <= wd_q;
              wreg_o  <= wreg_q;
              wdata_o <= alu_q;
            end else begin
              state <= LAST;
            end
          end
        end
        LAST: begin
          ldata_q <= fin_data;
          state   <= DONE;
          valid_o <= 1'b1;
          wd_o    <= wd_q;
          wreg_o  <= wreg_q;
          wdata_o <= ld_result;
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
          misalign_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access (DATA_W=32).
// A byte memory answers bus reads one cycle after the address; expected
// writeback results are queued at issue time and compared when valid_o rises.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        ex_valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_w_data_i;
  logic [4:0]  mem_op_i;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;

  mem_access #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_w_data_i(mem_w_data_i), .mem_op_i(mem_op_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o),
    .mem_din_i(mem_din_i), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LBU = 5'b10100;
  localparam logic [4:0] OP_LH  = 5'b10001;
  localparam logic [4:0] OP_LHU = 5'b10101;
  localparam logic [4:0] OP_LW  = 5'b10010;
  localparam logic [4:0] OP_LD  = 5'b10011;
  localparam logic [4:0] OP_SW  = 5'b11010;

  // Byte memory: preload in rom, bus writes land in ram.
  logic [7:0] rom [0:4095];
  logic [7:0] ram [0:4095];
  logic       wflag [0:4095];

  function automatic logic [7:0] peek(input logic [31:0] a);
    return wflag[a[11:0]] ? ram[a[11:0]] : rom[a[11:0]];
  endfunction

  always @(posedge clk) begin
    if (mem_wr_o) begin
      ram[mem_a_o[11:0]]   <= mem_dout_o;
      wflag[mem_a_o[11:0]] <= 1'b1;
    end
    mem_din_i <= peek(mem_a_o);
  end

  typedef struct {
    logic [39:0] aw;
  } wr_t;
  wr_t wrq[$];
  always @(negedge clk) if (mem_wr_o) wrq.push_back('{aw: {mem_a_o, mem_dout_o}});

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        mis;
    logic        chk_data;
    int          lat;
    int          reqc;
    int          d;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mext(input logic [31:0] raw, input int nb, input logic uns);
    case (nb)
      1:       return uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
      2:       return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Called just after a posedge; drives one instruction for one cycle.
  task automatic issue(input string tag, input logic [4:0] op, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] wdata,
                       input logic [31:0] sdata, input int d);
    exp_t        e;
    int          nb;
    logic [31:0] raw;
    nb  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    raw = '0;
    for (int i = 0; i < nb; i++) raw[i*8 +: 8] = peek(wdata + 32'(i));
    e.wd       = wd;
    e.wreg     = wreg;
    e.mis      = 1'b0;
    e.chk_data = 1'b1;
    e.d        = d;
    if (!op[4]) begin
      e.wdata = wdata; e.lat = 1; e.reqc = 0;
    end else if (op[3]) begin
      e.wdata = wdata; e.lat = d + 1 + nb + 1; e.reqc = d + 1 + nb;
    end else begin
      e.wdata = mext(raw, nb, op[2]); e.lat = d + 1 + nb + 2; e.reqc = d + 1 + nb + 1;
    end
`ifdef MEM_MISALIGN_CHK_EN
    if (op[4] && (wdata % nb) != 0) begin
      e.mis = 1'b1; e.wreg = 1'b0; e.chk_data = 1'b0; e.lat = 1; e.reqc = 0;
    end
`endif
    sbq.push_back(e);
    mem_gnt_i    = 1'b0;
    ex_valid_i   = 1'b1;
    mem_op_i     = op;
    wd_i         = wd;
    wreg_i       = wreg;
    wdata_i      = wdata;
    mem_w_data_i = sdata;
    @(negedge clk);
    chk({tag, "_stall0"}, 64'(stall_o), 64'(op[4]));
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
  endtask

  // Waits for valid_o, raising the grant after d refused WAIT_GNT cycles.
  task automatic wait_result(input string tag);
    exp_t e;
    int   lat;
    int   reqc;
    bit   found;
    e     = sbq[0];
    lat   = 0;
    reqc  = 0;
    found = 0;
    while (!found && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mem_req_o) reqc++;
      if (valid_o) found = 1;
      else begin
        if (e.reqc > 0 && lat <= e.d + 1) chk({tag, "_stall_wait"}, 64'(stall_o), 64'd1);
        if (lat == e.d + 1) mem_gnt_i = 1'b1;
      end
    end
    chk({tag, "_found"}, 64'(found), 64'd1);
    if (found) begin
      chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
      chk({tag, "_reqc"}, 64'(reqc), 64'(e.reqc));
      chk({tag, "_wreg"}, 64'(wreg_o), 64'(e.wreg));
      chk({tag, "_mis"}, 64'(misalign_o), 64'(e.mis));
      chk({tag, "_stall_done"}, 64'(stall_o), 64'd0);
      if (e.chk_data) begin
        chk({tag, "_wd"}, 64'(wd_o), 64'(e.wd));
        chk({tag, "_wdata"}, 64'(wdata_o), 64'(e.wdata));
      end
    end
    void'(sbq.pop_front());
    mem_gnt_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 64'(stall_o), 64'd0);
    chk({tag, "_req"}, 64'(mem_req_o), 64'd0);
    chk({tag, "_wr"}, 64'(mem_wr_o), 64'd0);
    chk({tag, "_a"}, 64'(mem_a_o), 64'd0);
    chk({tag, "_dout"}, 64'(mem_dout_o), 64'd0);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_wd"}, 64'(wd_o), 64'd0);
    chk({tag, "_wreg"}, 64'(wreg_o), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata_o), 64'd0);
    chk({tag, "_mis"}, 64'(misalign_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom[i]   = 8'(i * 7 + 3);
      ram[i]   = 8'h00;
      wflag[i] = 1'b0;
    end
    rom[12'h100] = 8'h78; rom[12'h101] = 8'h56; rom[12'h102] = 8'h34; rom[12'h103] = 8'h12;
    rom[12'h104] = 8'h9A; rom[12'h105] = 8'hBC;
    rom[12'h003] = 8'h80;

    rst = 1'b0; ex_valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_w_data_i = '0; mem_op_i = '0; mem_gnt_i = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    issue("alu", OP_ALU, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 0);
    wait_result("alu");
    issue("alu2", OP_ALU, 5'd17, 1'b0, 32'hA5A5_0F0F, 32'h0, 0);
    wait_result("alu2");

    issue("lw", OP_LW, 5'd3, 1'b1, 32'h100, 32'h0, 0);
    wait_result("lw");
    issue("lb", OP_LB, 5'd4, 1'b1, 32'h3, 32'h0, 0);
    wait_result("lb");
    issue("lbu", OP_LBU, 5'd4, 1'b1, 32'h3, 32'h0, 0);
    wait_result("lbu");

    wrq.delete();
    issue("sw", OP_SW, 5'd9, 1'b0, 32'h20, 32'hDEAD_BEEF, 3);
    wait_result("sw");
    chk("sw_nwr", 64'(wrq.size()), 64'd4);
    if (wrq.size() == 4) begin
      chk("sw_b0", 64'(wrq[0].aw), {24'h0, 32'h20, 8'hEF});
      chk("sw_b1", 64'(wrq[1].aw), {24'h0, 32'h21, 8'hBE});
      chk("sw_b2", 64'(wrq[2].aw), {24'h0, 32'h22, 8'hAD});
      chk("sw_b3", 64'(wrq[3].aw), {24'h0, 32'h23, 8'hDE});
    end
    issue("lw_back", OP_LW, 5'd6, 1'b1, 32'h20, 32'h0, 1);
    wait_result("lw_back");
    chk("lw_back_val", 64'(wdata_o), 64'hDEAD_BEEF);

    issue("lh", OP_LH, 5'd7, 1'b1, 32'h104, 32'h0, 0);
    wait_result("lh");
    issue("lhu", OP_LHU, 5'd8, 1'b1, 32'h104, 32'h0, 2);
    wait_result("lhu");
    issue("ld32", OP_LD, 5'd10, 1'b1, 32'h100, 32'h0, 0);
    wait_result("ld32");
    issue("lw_mis", OP_LW, 5'd11, 1'b1, 32'h102, 32'h0, 0);
    wait_result("lw_mis");

    // Reset in the second XFER cycle of a load.
    mem_op_i = OP_LW; wd_i = 5'd12; wreg_i = 1'b1; wdata_i = 32'h100; ex_valid_i = 1'b1;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1; ex_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("midrst_pre_req", 64'(mem_req_o), 64'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    mem_gnt_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    issue("post_rst", OP_ALU, 5'd21, 1'b1, 32'hCAFE_0001, 32'h0, 0);
    wait_result("post_rst");
    issue("post_rst_lb", OP_LB, 5'd22, 1'b1, 32'h101, 32'h0, 0);
    wait_result("post_rst_lb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, destination register index width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ex_valid_i  in  1  instruction presented from execute stage.
REQ-007 SHALL have port wd_i  in  REG_ADDR_W  destination register index.
REQ-008 SHALL have port wreg_i  in  1  register write enable.
REQ-009 SHALL have port wdata_i  in  DATA_W  ALU result; memory address for memory ops (low ADDR_W bits).
REQ-010 SHALL have port mem_w_data_i  in  DATA_W  store data.
REQ-011 SHALL have port mem_op_i  in  5  [4] mem op, [3] store, [2] unsigned load, [1:0] size 0=B,1=H,2=W,3=D.
REQ-012 SHALL have port stall_o  out  1  upstream holds all inputs while high.
REQ-013 SHALL have ports mem_req_o out 1 / mem_gnt_i in 1: memory bus request/grant.
REQ-014 SHALL have ports mem_a_o out ADDR_W, mem_wr_o out 1, mem_dout_o out 8, mem_din_i in 8: byte-wide bus, read data one cycle after address.
REQ-015 SHALL have ports valid_o out 1, wd_o out REG_ADDR_W, wreg_o out 1, wdata_o out DATA_W: registered writeback result.
REQ-016 SHALL have port misalign_o  out  1  misaligned-access flag (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_GNT, XFER, LAST, DONE.
REQ-018 IDLE, ex_valid_i=1, mem_op_i[4]=0: SHALL register wd_i/wreg_i/wdata_i to outputs with valid_o=1 next cycle (latency 1), stall_o=0.
REQ-019 IDLE, ex_valid_i=1, mem_op_i[4]=1: SHALL capture all inputs, assert stall_o combinationally that cycle, go to WAIT_GNT.
REQ-020 IDLE, ex_valid_i=0: SHALL drive valid_o=0 next cycle, hold other outputs.
REQ-021 WAIT_GNT: SHALL hold mem_req_o=1; on mem_gnt_i=1 go to XFER with byte counter cnt=0; wait indefinitely otherwise.
REQ-022 XFER: SHALL drive mem_a_o=addr+cnt (modulo 2^ADDR_W), mem_wr_o=store, mem_dout_o=store data byte cnt (little-endian); increment cnt each cycle.
REQ-023 Byte count N SHALL be 1/2/4/8 for size 0/1/2/3; size 3 with DATA_W=32 SHALL act as size 2.
REQ-024 Loads: SHALL capture mem_din_i as byte cnt-1 in XFER cycles with cnt>=1 and byte N-1 in LAST.
REQ-025 At cnt=N-1: stores SHALL go to DONE, loads to LAST; LAST SHALL go to DONE.
REQ-026 Loads SHALL sign-extend (mem_op_i[2]=0) or zero-extend (=1) the N-byte value to DATA_W into wdata_o.
REQ-027 Stores SHALL output wdata_o=captured address, wreg_o=captured wreg_i.
REQ-028 DONE: SHALL have valid_o=1 and final outputs registered, stall_o=0, mem_req_o=0, inputs ignored; next state IDLE.
REQ-029 stall_o SHALL be 1 in WAIT_GNT, XFER, LAST and in IDLE on accepting a memory op; else 0.
REQ-030 mem_req_o SHALL stay high from WAIT_GNT through the last XFER/LAST cycle; mem_wr_o SHALL be 0 outside XFER.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, cnt=0, stall_o=0, mem_req_o=0, mem_wr_o=0, mem_a_o=0, mem_dout_o=0, valid_o=0, wd_o=0, wreg_o=0, wdata_o=0, misalign_o=0, including mid-transfer; aborted accesses are not resumed.

Configuration
REQ-032 Macro MEM_MISALIGN_CHK_EN defined: a memory op whose address is not N-aligned SHALL not request the bus; it SHALL go IDLE->DONE with wreg_o=0, misalign_o=1 for the DONE cycle.
REQ-033 Macro undefined: misalign_o SHALL be tied 0 and misaligned accesses SHALL proceed byte-serially as normal.

Verification
REQ-034 Pass-through: IDLE, ex_valid_i=1, op=0, wd_i=5, wreg_i=1, wdata_i=0x1234 -> next cycle valid_o=1, wd_o=5, wdata_o=0x1234, stall_o=0.
REQ-035 LW at 0x100, gnt in first WAIT_GNT cycle, mem bytes 0x78,0x56,0x34,0x12 -> addresses 0x100..0x103 consecutive, valid_o=1 in cycle 7, wdata_o=0x12345678.
REQ-036 LB at 0x3 reading 0x80 -> wdata_o=0xFFFFFF80; LBU same -> 0x00000080; valid_o in cycle 4.
REQ-037 SW 0xDEADBEEF at 0x20, gnt delayed 3 cycles -> stall_o held, mem_wr_o=1 exactly 4 cycles with bytes EF,BE,AD,DE; valid_o=1, wreg_o=0 in DONE.
REQ-038 rst=0 during second XFER cycle of a load -> all outputs 0 immediately; after release, new op accepted from IDLE.
REQ-039 MEM_MISALIGN_CHK_EN defined, LW at 0x102 -> mem_req_o never asserted, misalign_o=1 and wreg_o=0 in cycle 1.
